// File: rtl/srl64_fifo.sv
// 64-deep first-word-fall-through FIFO built as two 32-stage shift-register halves.
// Define SRL64_FIFO_ERR_FLAGS_EN to add sticky OVF/UDF error outputs.
module srl64_fifo #(
  parameter int DATA_W   = 8,
  parameter int AF_LEVEL = 60
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              WR_EN,
  input  logic [DATA_W-1:0] DI,
  input  logic              RD_EN,
  output logic [DATA_W-1:0] DO,
  output logic              EMPTY,
  output logic              FULL,
  output logic              ALMOST_FULL,
  output logic [6:0]        COUNT,
  output logic [DATA_W-1:0] Q63
`ifdef SRL64_FIFO_ERR_FLAGS_EN
  ,
  output logic              OVF,
  output logic              UDF
`endif
);

  logic [DATA_W-1:0] lower_q [32];
  logic [DATA_W-1:0] upper_q [32];
  logic [6:0]        count_q, count_d;
  logic              wr_ok, rd_ok;
  logic [5:0]        rd_addr;

  assign EMPTY       = (count_q == 7'd0);
  assign FULL        = (count_q == 7'd64);
  assign ALMOST_FULL = (count_q >= 7'(AF_LEVEL));
  assign COUNT       = count_q;
  assign Q63         = upper_q[31];

  // A push at FULL is only accepted when a pop frees the slot in the same edge.
  assign wr_ok = WR_EN & (~FULL | RD_EN);
  assign rd_ok = RD_EN & ~EMPTY;

  // Head lives at stage COUNT-1; the top address bit picks the half like the F7 mux.
  assign rd_addr = 6'(count_q - 7'd1);
  assign DO      = rd_addr[5] ? upper_q[rd_addr[4:0]] : lower_q[rd_addr[4:0]];

  always_comb begin
    count_d = count_q;
    if (wr_ok && !rd_ok)      count_d = count_q + 7'd1;
    else if (rd_ok && !wr_ok) count_d = count_q - 7'd1;
  end

  // NOTE: storage has no reset, exactly like SRL primitives; EMPTY hides stale words.
  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      lower_q[0] <= DI;
      for (int k = 1; k < 32; k++) lower_q[k] <= lower_q[k-1];
      upper_q[0] <= lower_q[31];
      for (int k = 1; k < 32; k++) upper_q[k] <= upper_q[k-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) count_q <= 7'd0;
    else        count_q <= count_d;
  end

`ifdef SRL64_FIFO_ERR_FLAGS_EN
  logic ovf_q, udf_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (WR_EN && FULL && !RD_EN) ovf_q <= 1'b1;
      if (RD_EN && EMPTY)          udf_q <= 1'b1;
    end
  end

  assign OVF = ovf_q;
  assign UDF = udf_q;
`endif

endmodule

// File: tb/tb_srl64_fifo.sv
// Self-checking bench for srl64_fifo: queue-based reference model plus directed literal checks.
// Define SRL64_FIFO_ERR_FLAGS_EN to also exercise the sticky OVF/UDF outputs.
module tb_srl64_fifo;
  localparam int DW  = 8;
  localparam int AFL = 60;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] di = '0;
  logic [DW-1:0] dout, q63;
  logic          empty, full, almost_full;
  logic [6:0]    count;
`ifdef SRL64_FIFO_ERR_FLAGS_EN
  logic          ovf, udf;
`endif

  srl64_fifo #(.DATA_W(DW), .AF_LEVEL(AFL)) dut (
    .CLK(clk), .RST_N(rst_n), .WR_EN(wr_en), .DI(di), .RD_EN(rd_en),
    .DO(dout), .EMPTY(empty), .FULL(full), .ALMOST_FULL(almost_full),
    .COUNT(count), .Q63(q63)
`ifdef SRL64_FIFO_ERR_FLAGS_EN
    , .OVF(ovf), .UDF(udf)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue (index 0 = oldest) plus a log of
  // every word ever shifted in, which gives the last stage directly.
  logic [DW-1:0] fifo_m [$];
  logic [DW-1:0] hist_m [$];
  logic          ovf_m = 1'b0, udf_m = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_m.delete();
      ovf_m <= 1'b0;
      udf_m <= 1'b0;
    end else begin
      int  n;
      bit  push, pop;
      n    = fifo_m.size();
      push = wr_en && (n < 64 || rd_en);
      pop  = rd_en && n > 0;
      if (wr_en && n == 64 && !rd_en) ovf_m <= 1'b1;
      if (rd_en && n == 0)            udf_m <= 1'b1;
      if (pop)  void'(fifo_m.pop_front());
      if (push) begin
        fifo_m.push_back(di);
        hist_m.push_back(di);
        if (hist_m.size() > 64) void'(hist_m.pop_front());
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      int n;
      n = fifo_m.size();
      check("count", count, 64'(n));
      check("empty", empty, 64'(n == 0));
      check("full",  full,  64'(n == 64));
      check("almost_full", almost_full, 64'(n >= AFL));
      if (n > 0) check("do", dout, fifo_m[0]);
      if (hist_m.size() == 64) check("q63", q63, hist_m[0]);
`ifdef SRL64_FIFO_ERR_FLAGS_EN
      check("ovf", ovf, ovf_m);
      check("udf", udf, udf_m);
`endif
    end
  end

  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    wr_en = w; rd_en = r; di = d;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_af", almost_full, 0);
    rst_n = 1'b1;

    // Three pushes, FWFT latency 1, three pops
    step(1, 0, 8'h11);
    check("fwft_do", dout, 8'h11);
    check("fwft_empty", empty, 0);
    step(1, 0, 8'h22);
    step(1, 0, 8'h33);
    check("cnt3", count, 3);
    check("pop_a", dout, 8'h11); step(0, 1, 0);
    check("pop_b", dout, 8'h22); step(0, 1, 0);
    check("pop_c", dout, 8'h33); step(0, 1, 0);
    check("pop_empty", empty, 1);

    // Fill to 64, watch ALMOST_FULL and FULL
    for (int i = 0; i < 64; i++) begin
      step(1, 0, 8'(i));
      if (i == 58) check("af_59", almost_full, 0);
      if (i == 59) check("af_60", almost_full, 1);
      if (i == 62) check("full_63", full, 0);
    end
    check("full_64", full, 1);
    step(1, 0, 8'hAA);
    check("ovfpush_cnt", count, 64);
    check("ovfpush_q63", q63, 8'h00);
`ifdef SRL64_FIFO_ERR_FLAGS_EN
    check("ovf_set", ovf, 1);
`endif
    // Drain in order, crossing the upper/lower half boundary
    for (int i = 0; i < 64; i++) begin
      check("drain_do", dout, 8'(i));
      if (count == 7'd33) check("half_hi", dout, 8'h1F);
      step(0, 1, 0);
      if (i == 31) check("half_lo", dout, 8'h20);
    end
    check("drain_empty", empty, 1);
`ifdef SRL64_FIFO_ERR_FLAGS_EN
    check("ovf_sticky", ovf, 1);
`endif

    // Push+pop at FULL
    for (int i = 0; i < 64; i++) step(1, 0, 8'(i));
    step(1, 1, 8'h55);
    check("pp_full_cnt", count, 64);
    check("pp_full_do", dout, 8'h01);
    repeat (63) step(0, 1, 0);
    check("pp_full_tail", dout, 8'h55);
    check("pp_full_cnt1", count, 1);
    step(0, 1, 0);

    // Push+pop at EMPTY, pop at EMPTY, push+pop at COUNT=1
    step(1, 1, 8'h77);
    check("pp_empty_cnt", count, 1);
    check("pp_empty_do", dout, 8'h77);
    step(0, 1, 0);
    step(0, 1, 0);
    check("pop_at_empty", count, 0);
`ifdef SRL64_FIFO_ERR_FLAGS_EN
    check("udf_set", udf, 1);
`endif
    step(1, 0, 8'h42);
    step(1, 1, 8'h43);
    check("pp_one_cnt", count, 1);
    check("pp_one_do", dout, 8'h43);
    step(0, 1, 0);

    // Randomised traffic in phases biased toward filling and draining
    for (int ph = 0; ph < 12; ph++) begin
      int wp;
      wp = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 15 : 50;
      for (int c = 0; c < 200; c++)
        step($urandom_range(99) < wp, $urandom_range(99) < (100 - wp), 8'($urandom));
    end

    // Asynchronous reset mid-operation
    while (count != 0) step(0, 1, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 8'(8'hC0 + i));
    #2 rst_n = 1'b0;
    #1;
    check("amid_empty", empty, 1);
    check("amid_count", count, 0);
`ifdef SRL64_FIFO_ERR_FLAGS_EN
    check("amid_ovf", ovf, 0);
    check("amid_udf", udf, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 8'h99);
    check("post_rst_do", dout, 8'h99);
    check("post_rst_cnt", count, 1);
    step(0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
